// File: rtl/sb_incr_stage.sv
// rtl/sb_incr_stage.sv - switchboard stream stage: per-byte increment, 2-entry skid, packet counter, terminator detect
module sb_incr_stage #(
    parameter int         DW  = 256,
    parameter logic [7:0] INC = 8'd1,
    parameter int         CW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic [31:0]   in_dest,
    input  logic          in_last,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic [31:0]   out_dest,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] pkt_count,
    output logic          done
);
    localparam int NB = DW / 8;

    logic [DW-1:0] r_m_data;
    logic [31:0]   r_m_dest;
    logic          r_m_last;
    logic          r_m_valid;
    logic [DW-1:0] r_s_data;
    logic [31:0]   r_s_dest;
    logic          r_s_last;
    logic          r_s_valid;
    logic [CW-1:0] r_pkt_count;
    logic          r_done;

    logic [DW-1:0] w_xf_data;
    logic          w_term;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_load;

    always_comb begin
        w_xf_data = '0;
        for (int i = 0; i < NB; i++) begin
            w_xf_data[8*i +: 8] = in_data[8*i +: 8] + INC;
        end
    end

    // in_ready is a pure function of flops so the stage never chains out_ready upstream
    assign in_ready   = !r_s_valid && !r_done;
    assign w_term     = &in_data;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_m_valid && out_ready;
    assign w_load     = w_in_fire && !w_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_data    <= '0;
            r_m_dest    <= '0;
            r_m_last    <= 1'b0;
            r_m_valid   <= 1'b0;
            r_s_data    <= '0;
            r_s_dest    <= '0;
            r_s_last    <= 1'b0;
            r_s_valid   <= 1'b0;
            r_pkt_count <= '0;
            r_done      <= 1'b0;
        end else begin
            if (w_out_fire && r_m_last) begin
                r_pkt_count <= r_pkt_count + {{(CW-1){1'b0}}, 1'b1};
            end
            if (w_in_fire && w_term) begin
                r_done <= 1'b1;
            end
            if (w_out_fire) begin
                if (r_s_valid) begin
                    r_m_data  <= r_s_data;
                    r_m_dest  <= r_s_dest;
                    r_m_last  <= r_s_last;
                    r_s_valid <= 1'b0;
                end else if (w_load) begin
                    r_m_data  <= w_xf_data;
                    r_m_dest  <= in_dest;
                    r_m_last  <= in_last;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end else if (w_load) begin
                // S can only be empty here: a full S forces in_ready low
                if (!r_m_valid) begin
                    r_m_data  <= w_xf_data;
                    r_m_dest  <= in_dest;
                    r_m_last  <= in_last;
                    r_m_valid <= 1'b1;
                end else begin
                    r_s_data  <= w_xf_data;
                    r_s_dest  <= in_dest;
                    r_s_last  <= in_last;
                    r_s_valid <= 1'b1;
                end
            end
        end
    end

    assign out_data  = r_m_data;
    assign out_dest  = r_m_dest;
    assign out_last  = r_m_last;
    assign out_valid = r_m_valid;
    assign pkt_count = r_pkt_count;
    assign done      = r_done;
endmodule

// File: tb/tb_sb_incr_stage.sv
// tb/tb_sb_incr_stage.sv - self-checking bench for sb_incr_stage
module tb_sb_incr_stage;
    localparam int DW = 256;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic [31:0]   in_dest = '0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   out_dest;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] pkt_count;
    logic          done;

    sb_incr_stage #(.DW(DW), .INC(8'd1), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_dest(out_dest), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .pkt_count(pkt_count), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] xf(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < DW/8; i++) r[8*i +: 8] = d[8*i +: 8] + 8'd1;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of transformed beats held inside the stage
    typedef struct {
        logic [DW-1:0] data;
        logic [31:0]   dest;
        logic          last;
    } beat_t;

    beat_t         mq[$];
    int            m_cnt = 0;
    logic          m_done = 1'b0;
    bit            m_known = 1'b0;
    bit            m_in_fired = 1'b0;

    always @(negedge clk) begin
        logic exp_ready;
        logic exp_oval;
        exp_ready = (mq.size() < 2) && !m_done;
        exp_oval  = (mq.size() > 0);
        if (m_known) begin
            chk("mon_out_valid", DW'(out_valid), DW'(exp_oval));
            chk("mon_in_ready", DW'(in_ready), DW'(exp_ready));
            chk("mon_pkt_count", DW'(pkt_count), DW'(m_cnt));
            chk("mon_done", DW'(done), DW'(m_done));
            if (exp_oval) begin
                chk("mon_out_data", out_data, mq[0].data);
                chk("mon_out_dest", DW'(out_dest), DW'(mq[0].dest));
                chk("mon_out_last", DW'(out_last), DW'(mq[0].last));
            end
        end
        m_in_fired = in_valid && exp_ready;
        if (rst) begin
            mq.delete();
            m_cnt   = 0;
            m_done  = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (exp_oval && out_ready) begin
                if (mq[0].last) m_cnt = (m_cnt + 1) % (1 << CW);
                void'(mq.pop_front());
            end
            if (m_in_fired) begin
                if (&in_data) m_done = 1'b1;
                else mq.push_back('{xf(in_data), in_dest, in_last});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_pkt_count", DW'(pkt_count), '0);
        chk("rst_done", DW'(done), '0);
        rst = 1'b0;
        chk("rst_in_ready", DW'(in_ready), DW'(1));
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic [31:0]   dest;
        logic          last;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [DW-1:0] a, b, c, x;
        int cnt;
        for (int i = 0; i < 32; i++) begin
            tbl[0].data[8*i +: 8] = 8'(i);
            tbl[0].exp[8*i +: 8]  = 8'(i + 1);
        end
        tbl[0].dest = 32'h5; tbl[0].last = 1'b1;
        tbl[1] = '{{{31{8'h10}}, 8'hFF}, 32'h7, 1'b0, {{31{8'h11}}, 8'h00}};
        tbl[2] = '{{32{8'hFE}}, 32'hA5A5_0001, 1'b1, {32{8'hFF}}};
        tbl[3] = '{{16{16'h7F80}}, 32'hFFFF_FFFF, 1'b0, {16{16'h8081}}};
        tbl[4] = '{'0, 32'h0, 1'b1, {32{8'h01}}};

        // Single-beat vectors
        do_reset();
        cnt = 0;
        out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            in_data = tbl[v].data; in_dest = tbl[v].dest; in_last = tbl[v].last;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk("vec_out_valid", DW'(out_valid), DW'(1));
            chk("vec_out_data", out_data, tbl[v].exp);
            chk("vec_out_dest", DW'(out_dest), DW'(tbl[v].dest));
            chk("vec_out_last", DW'(out_last), DW'(tbl[v].last));
            step();
            if (tbl[v].last) cnt++;
            chk("vec_pkt_count", DW'(pkt_count), DW'(cnt));
            chk("vec_done", DW'(done), '0);
        end

        // Backpressure: A in M, B in S, C waits
        do_reset();
        out_ready = 1'b0;
        a = rand_data(); b = rand_data(); c = rand_data();
        in_data = a; in_dest = 1; in_last = 0; in_valid = 1'b1;
        step();
        chk("bp_a_out", out_data, xf(a));
        chk("bp_ready_after_a", DW'(in_ready), DW'(1));
        in_data = b; in_dest = 2;
        step();
        chk("bp_ready_after_b", DW'(in_ready), '0);
        in_data = c; in_dest = 3; in_last = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_hold_a", out_data, xf(a));
            chk("bp_hold_ready", DW'(in_ready), '0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_b_out", out_data, xf(b));
        chk("bp_b_dest", DW'(out_dest), DW'(2));
        step();
        in_valid = 1'b0;
        chk("bp_c_out", out_data, xf(c));
        chk("bp_c_dest", DW'(out_dest), DW'(3));
        step();
        chk("bp_drained", DW'(out_valid), '0);

        // Streaming 100 beats
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_data = rand_data(); in_dest = k; in_last = ((k + 1) % 10 == 0);
            in_valid = 1'b1;
            step();
            chk("stream_out_valid", DW'(out_valid), DW'(1));
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", DW'(out_valid), '0);
        chk("stream_pkt_count", DW'(pkt_count), DW'(10));

        // Terminator while X is held in M
        do_reset();
        out_ready = 1'b0;
        x = rand_data();
        in_data = x; in_dest = 32'h99; in_last = 1'b0; in_valid = 1'b1;
        step();
        in_data = '1; in_last = 1'b1;
        step();
        in_valid = 1'b0;
        chk("term_done", DW'(done), DW'(1));
        chk("term_in_ready", DW'(in_ready), '0);
        chk("term_x_held", out_data, xf(x));
        out_ready = 1'b1;
        step();
        chk("term_no_fwd", DW'(out_valid), '0);
        chk("term_no_count", DW'(pkt_count), '0);
        step();
        chk("term_still_done", DW'(done), DW'(1));
        chk("term_still_blocked", DW'(in_ready), '0);

        // Reset mid-stream with pkt_count=15 and M, S full
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            in_data = rand_data(); in_dest = k; in_last = 1'b1; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("mid_pkt15", DW'(pkt_count), DW'(15));
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = rand_data();
        step();
        in_data = rand_data();
        step();
        in_valid = 1'b0;
        chk("mid_s_full", DW'(in_ready), '0);
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", DW'(out_valid), '0);
        chk("mid_rst_pkt", DW'(pkt_count), '0);
        chk("mid_rst_done", DW'(done), '0);
        step();
        chk("mid_no_spurious", DW'(out_valid), '0);
        chk("mid_ready", DW'(in_ready), DW'(1));

        // Counter wrap 15 -> 0
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_data = rand_data(); in_dest = k; in_last = 1'b1; in_valid = 1'b1;
            step();
            if (k == 15) chk("wrap_at15", DW'(pkt_count), DW'(15));
        end
        in_valid = 1'b0;
        step();
        chk("wrap_to0", DW'(pkt_count), '0);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if (in_valid && !m_in_fired) begin
                if ($urandom_range(3) == 0) in_valid = 1'b0;
            end else begin
                in_valid = ($urandom_range(2) != 0);
                in_data  = rand_data();
                in_dest  = $urandom;
                in_last  = ($urandom_range(3) == 0);
            end
            out_ready = ($urandom_range(2) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("rand_drained", DW'(out_valid), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
